// File: rtl/ami_pkg.sv
// Shared types and constants for the AXI4 master interface (ami).
// Bus widths, burst/response encodings, error flag positions and the FSM state type.
package ami_pkg;

  localparam int AXI_DW     = 128;
  localparam int AXI_AW     = 40;
  localparam int AXI_IW     = 8;
  localparam int AXI_LW     = 8;
  localparam int AXI_SW     = 3;
  localparam int AXI_BYTES  = AXI_DW / 8;
  localparam int AXI_WSTRBW = AXI_BYTES;

  localparam logic [AXI_SW-1:0] MAX_SIZE = AXI_SW'($clog2(AXI_BYTES));

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ERR_CHK  = 0;
  localparam int ERR_ID   = 1;
  localparam int ERR_LAST = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_DONE
  } state_e;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ami_if.sv
// AXI4 link between the ami initiator and a slave.
// The master modport is the ami side; the slave modport is the fabric/target side.
interface ami_if import ami_pkg::*; ();

  logic [AXI_IW-1:0]     AWID;
  logic [AXI_AW-1:0]     AWADDR;
  logic [AXI_LW-1:0]     AWLEN;
  logic [AXI_SW-1:0]     AWSIZE;
  logic [1:0]            AWBURST;
  logic [3:0]            AWCACHE;
  logic [2:0]            AWPROT;
  logic [3:0]            AWQOS;
  logic [3:0]            AWREGION;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [AXI_DW-1:0]     WDATA;
  logic [AXI_WSTRBW-1:0] WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;

  logic [AXI_IW-1:0]     BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [AXI_IW-1:0]     ARID;
  logic [AXI_AW-1:0]     ARADDR;
  logic [AXI_LW-1:0]     ARLEN;
  logic [AXI_SW-1:0]     ARSIZE;
  logic [1:0]            ARBURST;
  logic [3:0]            ARCACHE;
  logic [2:0]            ARPROT;
  logic [3:0]            ARQOS;
  logic [3:0]            ARREGION;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [AXI_IW-1:0]     RID;
  logic [AXI_DW-1:0]     RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWCACHE, AWPROT, AWQOS, AWREGION, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, ARQOS, ARREGION, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWCACHE, AWPROT, AWQOS, AWREGION, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, ARQOS, ARREGION, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

endinterface

// File: rtl/ami_cmd_chk.sv
// Combinational legality check for a captured burst command.
// Rejects bursts that cross a 4KB page or whose beat size exceeds the bus width.
module ami_cmd_chk import ami_pkg::*; (
  input  logic [11:0]       addr_lo_i,
  input  logic [AXI_LW-1:0] len_i,
  input  logic [AXI_SW-1:0] size_i,
  output logic              reject_o
);

  logic [12:0] bytes;
  logic [12:0] sum;

  // 13 bits hold 4095 + 4096 for every legal size; oversize beats are rejected anyway.
  always_comb begin
    bytes    = (13'(len_i) + 13'd1) << size_i;
    sum      = {1'b0, addr_lo_i} + bytes;
    reject_o = (size_i > MAX_SIZE) || (sum > 13'd4096);
  end

endmodule

// File: rtl/ami.sv
// AXI4 master interface: single-outstanding, in-order, INCR-only burst initiator.
// Takes one user command at a time, runs the AW/W/B or AR/R phases and reports one completion.
module ami import ami_pkg::*; (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  ami_if.master                 axi,

  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [AXI_AW-1:0]     cmd_addr_i,
  input  logic [AXI_LW-1:0]     cmd_len_i,
  input  logic [AXI_SW-1:0]     cmd_size_i,
  input  logic [AXI_IW-1:0]     cmd_id_i,

  input  logic                  wd_valid_i,
  output logic                  wd_ready_o,
  input  logic [AXI_DW-1:0]     wd_data_i,
  input  logic [AXI_WSTRBW-1:0] wd_strb_i,

  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [AXI_DW-1:0]     rd_data_o,
  output logic [1:0]            rd_resp_o,
  output logic                  rd_last_o,

  output logic                  done_valid_o,
  output logic                  done_write_o,
  output logic [1:0]            done_resp_o,
  output logic [2:0]            done_err_o
);

  state_e              state_q, state_d;
  logic                alive_q;
  logic                write_q;
  logic [AXI_AW-1:0]   addr_q;
  logic [AXI_LW-1:0]   len_q;
  logic [AXI_SW-1:0]   size_q;
  logic [AXI_IW-1:0]   id_q;
  logic [AXI_LW-1:0]   cnt_q, cnt_d;
  logic [1:0]          resp_q, resp_d;
  logic [2:0]          err_q, err_d;
  logic                reject;
  logic                cmd_fire;
  logic                last_beat;
  logic                in_w, in_r, in_done;

  ami_cmd_chk u_chk (
    .addr_lo_i (addr_q[11:0]),
    .len_i     (len_q),
    .size_i    (size_q),
    .reject_o  (reject)
  );

  // alive_q keeps cmd_ready low until the first clock after reset is released.
  assign cmd_fire  = (state_q == S_IDLE) && alive_q && cmd_valid_i;
  assign last_beat = (cnt_q == len_q);
  assign in_w      = (state_q == S_W);
  assign in_r      = (state_q == S_R);
  assign in_done   = (state_q == S_DONE);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      alive_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      resp_q  <= RESP_OKAY;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      if (cmd_fire) begin
        write_q <= cmd_write_i;
        addr_q  <= cmd_addr_i;
        len_q   <= cmd_len_i;
        size_q  <= cmd_size_i;
        id_q    <= cmd_id_i;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_d       = resp_q;
    err_d        = err_q;
    cmd_ready_o  = 1'b0;
    axi.AWVALID  = 1'b0;
    axi.WVALID   = 1'b0;
    wd_ready_o   = 1'b0;
    axi.BREADY   = 1'b0;
    axi.ARVALID  = 1'b0;
    axi.RREADY   = 1'b0;
    rd_valid_o   = 1'b0;
    done_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = alive_q;
        if (cmd_fire) begin
          state_d = S_CHK;
          cnt_d   = '0;
          resp_d  = RESP_OKAY;
          err_d   = '0;
        end
      end
      S_CHK: begin
        if (reject) begin
          resp_d         = RESP_SLVERR;
          err_d[ERR_CHK] = 1'b1;
          state_d        = S_DONE;
        end else begin
          state_d = write_q ? S_AW : S_AR;
        end
      end
      S_AW: begin
        axi.AWVALID = 1'b1;
        if (axi.AWREADY) state_d = S_W;
      end
      S_W: begin
        axi.WVALID = wd_valid_i;
        wd_ready_o = axi.WREADY;
        if (wd_valid_i && axi.WREADY) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = S_B;
        end
      end
      S_B: begin
        axi.BREADY = 1'b1;
        if (axi.BVALID) begin
          resp_d = axi.BRESP;
          if (axi.BID != id_q) err_d[ERR_ID] = 1'b1;
          state_d = S_DONE;
        end
      end
      S_AR: begin
        axi.ARVALID = 1'b1;
        if (axi.ARREADY) state_d = S_R;
      end
      S_R: begin
        axi.RREADY = rd_ready_i;
        rd_valid_o = axi.RVALID;
        if (axi.RVALID && rd_ready_i) begin
          resp_d = resp_max(resp_q, axi.RRESP);
          if (axi.RID != id_q) err_d[ERR_ID] = 1'b1;
          if (axi.RLAST != last_beat) err_d[ERR_LAST] = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (axi.RLAST || last_beat) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_valid_o = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign axi.AWID     = id_q;
  assign axi.AWADDR   = addr_q;
  assign axi.AWLEN    = len_q;
  assign axi.AWSIZE   = size_q;
  assign axi.AWBURST  = BURST_INCR;
  assign axi.AWCACHE  = '0;
  assign axi.AWPROT   = '0;
  assign axi.AWQOS    = '0;
  assign axi.AWREGION = '0;

  assign axi.ARID     = id_q;
  assign axi.ARADDR   = addr_q;
  assign axi.ARLEN    = len_q;
  assign axi.ARSIZE   = size_q;
  assign axi.ARBURST  = BURST_INCR;
  assign axi.ARCACHE  = '0;
  assign axi.ARPROT   = '0;
  assign axi.ARQOS    = '0;
  assign axi.ARREGION = '0;

  // Data paths are gated by state so an abandoned burst leaves nothing on the outputs.
  assign axi.WDATA    = in_w ? wd_data_i : '0;
  assign axi.WSTRB    = in_w ? wd_strb_i : '0;
  assign axi.WLAST    = in_w && last_beat;

  assign rd_data_o    = in_r ? axi.RDATA : '0;
  assign rd_resp_o    = in_r ? axi.RRESP : '0;
  assign rd_last_o    = in_r && axi.RLAST;

  assign done_write_o = in_done && write_q;
  assign done_resp_o  = in_done ? resp_q : '0;
  assign done_err_o   = in_done ? err_q : '0;

endmodule

// File: tb/tb_ami.sv
// Self-checking bench for ami: table of burst commands against a cycle-based AXI slave model,
// with scoreboards for write and read beats and hand-written reset sequences.
module tb_ami;
  import ami_pkg::*;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  ami_if axi ();

  logic                  cmd_valid, cmd_ready, cmd_write;
  logic [AXI_AW-1:0]     cmd_addr;
  logic [AXI_LW-1:0]     cmd_len;
  logic [AXI_SW-1:0]     cmd_size;
  logic [AXI_IW-1:0]     cmd_id;
  logic                  wd_valid, wd_ready;
  logic [AXI_DW-1:0]     wd_data;
  logic [AXI_WSTRBW-1:0] wd_strb;
  logic                  rd_valid, rd_ready;
  logic [AXI_DW-1:0]     rd_data;
  logic [1:0]            rd_resp;
  logic                  rd_last;
  logic                  done_valid, done_write;
  logic [1:0]            done_resp;
  logic [2:0]            done_err;

  ami dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .axi(axi),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_size_i(cmd_size), .cmd_id_i(cmd_id),
    .wd_valid_i(wd_valid), .wd_ready_o(wd_ready), .wd_data_i(wd_data), .wd_strb_i(wd_strb),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data), .rd_resp_o(rd_resp),
    .rd_last_o(rd_last), .done_valid_o(done_valid), .done_write_o(done_write),
    .done_resp_o(done_resp), .done_err_o(done_err)
  );

  typedef struct {
    bit          write;
    logic [39:0] addr;
    int          len;
    int          size;
    logic [7:0]  id;
    int          awDelay;
    bit          randMode;
    logic [1:0]  bresp;
    bit          idBad;
    int          errBeat;
    int          rlastAt;
    logic [1:0]  expResp;
    logic [2:0]  expErr;
    int          expBeats;
  } vec_t;

  typedef struct packed { logic [127:0] data; logic [15:0] strb; logic last; } wexp_t;
  typedef struct packed { logic [127:0] data; logic [1:0] resp; logic last; } rexp_t;

  vec_t  vecs[13];
  vec_t  cur;
  wexp_t wq[$];
  rexp_t rq[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  bit cmdPending, awDone, wdActive, wdPresent, bPending, rActive, rPresent, doneSeen;
  int awWait, wdIdx, wBeats, rIdx, rBeats, hsCycle, addrCycle, doneCycle;
  logic [1:0] curRresp, seenResp;
  logic curRlast, seenWrite;
  logic [2:0] seenErr;

  function automatic logic [127:0] wdat(int i);
    return {32'hC0DE_0000 + 32'(i), 32'(i * 7), 32'hA5A5_0000 ^ 32'(i), 32'(i)};
  endfunction

  function automatic logic [15:0] wstrbf(int i);
    return 16'hFFFF ^ 16'(i * 3);
  endfunction

  function automatic logic [127:0] rdat(int i);
    return {32'h5EAD_0000 + 32'(i), ~32'(i), 32'(i * 13), 32'h1234_0000 | 32'(i)};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic resetModel();
    awWait = cur.awDelay; awDone = 0; wdActive = 0; wdPresent = 0; wdIdx = 0; wBeats = 0;
    bPending = 0; rActive = 0; rPresent = 0; rIdx = 0; rBeats = 0; doneSeen = 0;
    hsCycle = -1; addrCycle = -1; doneCycle = -1;
    wq.delete(); rq.delete();
  endtask

  // One clock of the user source/sink and AXI slave model: drive after the falling edge, sample 1ns later.
  task automatic stepCycle();
    wexp_t we;
    rexp_t re;
    @(negedge ACLK);
    cycle++;
    cmd_valid = cmdPending;
    axi.AWREADY = (awWait <= 0);
    axi.ARREADY = (awWait <= 0);
    axi.WREADY  = cur.randMode ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (wdActive && !wdPresent && wdIdx <= cur.len && (!cur.randMode || $urandom_range(0, 3) != 0)) begin
      wdPresent = 1;
      wq.push_back('{wdat(wdIdx), wstrbf(wdIdx), (wdIdx == cur.len)});
    end
    wd_valid = wdPresent;
    wd_data  = wdat(wdIdx);
    wd_strb  = wstrbf(wdIdx);
    axi.BVALID = bPending;
    axi.BID    = cur.id ^ {7'b0, cur.idBad};
    axi.BRESP  = cur.bresp;
    if (rActive && !rPresent && (!cur.randMode || $urandom_range(0, 3) != 0)) begin
      rPresent = 1;
      curRresp = (rIdx == cur.errBeat) ? RESP_SLVERR : RESP_OKAY;
      curRlast = (cur.rlastAt < 0) ? (rIdx == cur.len) : (rIdx == cur.rlastAt);
      rq.push_back('{rdat(rIdx), curRresp, curRlast});
    end
    axi.RVALID = rPresent;
    axi.RDATA  = rdat(rIdx);
    axi.RRESP  = curRresp;
    axi.RLAST  = curRlast;
    axi.RID    = cur.id ^ {7'b0, cur.idBad};
    rd_ready   = cur.randMode ? cycle[0] : 1'b1;
    #1;
    if (cmd_valid && cmd_ready) begin
      cmdPending = 0;
      hsCycle = cycle;
      if (cur.write) wdActive = 1;
    end
    if (!awDone) checkOutput("w_before_aw", axi.WVALID, 1'b0);
    if (axi.AWVALID) begin
      if (addrCycle < 0) addrCycle = cycle;
      checkOutput("aw_payload", {axi.AWID, axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST},
                  {cur.id, cur.addr, 8'(cur.len), 3'(cur.size), BURST_INCR});
      if (axi.AWREADY) awDone = 1; else awWait--;
    end
    if (axi.ARVALID) begin
      if (addrCycle < 0) addrCycle = cycle;
      checkOutput("ar_payload", {axi.ARID, axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST},
                  {cur.id, cur.addr, 8'(cur.len), 3'(cur.size), BURST_INCR});
      if (axi.ARREADY) rActive = 1; else awWait--;
    end
    if (axi.WVALID && axi.WREADY) begin
      if (wq.size() == 0) checkOutput("w_unexpected_beat", 1'b1, 1'b0);
      else begin
        we = wq.pop_front();
        checkOutput("wdata", axi.WDATA, we.data);
        checkOutput("wstrb", axi.WSTRB, we.strb);
        checkOutput("wlast", axi.WLAST, we.last);
      end
      wdPresent = 0;
      wdIdx++;
      wBeats++;
      if (wBeats == cur.len + 1) bPending = 1;
    end
    if (axi.BVALID && axi.BREADY) bPending = 0;
    if (rd_valid && rd_ready) begin
      if (rq.size() == 0) checkOutput("rd_unexpected_beat", 1'b1, 1'b0);
      else begin
        re = rq.pop_front();
        checkOutput("rd_data", rd_data, re.data);
        checkOutput("rd_resp", rd_resp, re.resp);
        checkOutput("rd_last", rd_last, re.last);
      end
    end
    if (axi.RVALID && axi.RREADY) begin
      rPresent = 0;
      rBeats++;
      rIdx++;
      if (curRlast || rIdx > cur.len) rActive = 0;
    end
    if (done_valid) begin
      doneSeen = 1;
      doneCycle = cycle;
      seenResp = done_resp;
      seenErr = done_err;
      seenWrite = done_write;
    end
  endtask

  // Issue one command, run until its completion pulse, then compare the outcome with the vector.
  task automatic applyStimulus(input vec_t v, input string tag);
    int n;
    cur = v;
    resetModel();
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_len   = 8'(v.len);
    cmd_size  = 3'(v.size);
    cmd_id    = v.id;
    cmdPending = 1;
    n = 0;
    while (!doneSeen && n < 3000) begin
      stepCycle();
      n++;
    end
    if (!doneSeen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no_done required=done", tag);
    end else begin
      checkOutput({tag, "_done_resp"}, seenResp, v.expResp);
      checkOutput({tag, "_done_err"}, seenErr, v.expErr);
      checkOutput({tag, "_done_write"}, seenWrite, v.write);
      checkOutput({tag, "_beats"}, v.write ? wBeats : rBeats, v.expBeats);
      if (v.expErr[0]) begin
        checkOutput({tag, "_reject_latency"}, doneCycle - hsCycle, 2);
        checkOutput({tag, "_reject_no_bus"}, addrCycle >= 0, 1'b0);
      end else begin
        checkOutput({tag, "_addr_latency"}, addrCycle - hsCycle, 2);
        checkOutput({tag, "_queues_drained"}, wq.size() + rq.size(), 0);
      end
    end
    wdActive = 0;
    wdPresent = 0;
    rActive = 0;
    rPresent = 0;
    bPending = 0;
    stepCycle();
    checkOutput({tag, "_done_one_cycle"}, done_valid, 1'b0);
    checkOutput({tag, "_ready_after_done"}, cmd_ready, 1'b1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valids"},
                {cmd_ready, axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY, axi.ARVALID, axi.RREADY,
                 wd_ready, rd_valid, rd_last, done_valid, done_write},
                12'b0);
    checkOutput({tag, "_done_fields"}, {done_resp, done_err}, 5'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    //           wr   addr         len  sz id     dly rnd bresp  idb eb  rl   eResp  eErr    beats
    vecs[0]  = '{1'b1, 40'h1000,    3,  4, 8'h05, 0,  1'b0, 2'b00, 1'b0, -1, -1, 2'b00, 3'b000, 4};
    vecs[1]  = '{1'b0, 40'h2000,    7,  4, 8'h11, 0,  1'b1, 2'b00, 1'b0,  3, -1, 2'b10, 3'b000, 8};
    vecs[2]  = '{1'b1, 40'h0FF0,    1,  4, 8'h22, 0,  1'b0, 2'b00, 1'b0, -1, -1, 2'b10, 3'b001, 0};
    vecs[3]  = '{1'b0, 40'h3000,    3,  4, 8'h33, 0,  1'b0, 2'b00, 1'b1, -1,  1, 2'b00, 3'b110, 2};
    vecs[4]  = '{1'b1, 40'h4008,    2,  3, 8'h44, 10, 1'b0, 2'b00, 1'b0, -1, -1, 2'b00, 3'b000, 3};
    vecs[5]  = '{1'b1, 40'h5000,    0,  5, 8'h55, 0,  1'b0, 2'b00, 1'b0, -1, -1, 2'b10, 3'b001, 0};
    vecs[6]  = '{1'b1, 40'h0F00,   15,  4, 8'h66, 0,  1'b1, 2'b00, 1'b0, -1, -1, 2'b00, 3'b000, 16};
    vecs[7]  = '{1'b1, 40'h5004,    0,  2, 8'h77, 0,  1'b0, 2'b01, 1'b0, -1, -1, 2'b01, 3'b000, 1};
    vecs[8]  = '{1'b0, 40'h6000,  255,  0, 8'h88, 0,  1'b0, 2'b00, 1'b0, -1, -1, 2'b00, 3'b000, 256};
    vecs[9]  = '{1'b1, 40'h7000,    1,  4, 8'h99, 0,  1'b0, 2'b11, 1'b1, -1, -1, 2'b11, 3'b010, 2};
    vecs[10] = '{1'b0, 40'h8000,    2,  4, 8'hAA, 0,  1'b0, 2'b00, 1'b0, -1, 99, 2'b00, 3'b100, 3};
    vecs[11] = '{1'b0, 40'h0FFF,    0,  0, 8'hBB, 3,  1'b0, 2'b00, 1'b0, -1, -1, 2'b00, 3'b000, 1};
    vecs[12] = '{1'b0, 40'h0FFF,    1,  0, 8'hCC, 0,  1'b0, 2'b00, 1'b0, -1, -1, 2'b10, 3'b001, 0};

    cur = '{1'b0, 40'h0, 0, 0, 8'h0, 0, 1'b0, 2'b00, 1'b0, -1, -1, 2'b00, 3'b000, 0};
    cmdPending = 0;
    curRresp = 2'b00;
    curRlast = 1'b0;
    resetModel();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_id = '0;
    wd_valid = 0; wd_data = '0; wd_strb = '0; rd_ready = 0;
    axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BID = '0; axi.BRESP = '0;
    axi.ARREADY = 0; axi.RVALID = 0; axi.RID = '0; axi.RDATA = '0; axi.RRESP = '0; axi.RLAST = 0;

    $display("[TB] reset phase");
    repeat (3) @(negedge ACLK);
    #1;
    checkResetOutputs("reset");
    checkOutput("tieoffs", {axi.AWCACHE, axi.AWPROT, axi.AWQOS, axi.AWREGION,
                            axi.ARCACHE, axi.ARPROT, axi.ARQOS, axi.ARREGION}, 30'b0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    checkOutput("cmd_ready_at_release", cmd_ready, 1'b0);
    stepCycle();
    checkOutput("cmd_ready_after_release", cmd_ready, 1'b1);

    $display("[TB] table of %0d commands", $size(vecs));
    for (int i = 0; i < $size(vecs); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    $display("[TB] reset during beat 3 of a len 15 write");
    cur = '{1'b1, 40'hA000, 15, 4, 8'hE1, 0, 1'b0, 2'b00, 1'b0, -1, -1, 2'b00, 3'b000, 16};
    resetModel();
    cmd_write = 1'b1; cmd_addr = cur.addr; cmd_len = 8'd15; cmd_size = 3'd4; cmd_id = cur.id;
    cmdPending = 1;
    n = 0;
    while (wBeats < 2 && n < 200) begin
      stepCycle();
      n++;
    end
    checkOutput("midreset_reached_beat3", wBeats, 2);
    stepCycle();
    checkOutput("midreset_wvalid_beat3", axi.WVALID, 1'b1);
    ARESETn = 1'b0;
    #1;
    checkResetOutputs("midreset");
    cmdPending = 0;
    cur.write = 1'b0;
    resetModel();
    stepCycle();
    stepCycle();
    checkResetOutputs("midreset_held");
    ARESETn = 1'b1;
    stepCycle();
    checkOutput("midreset_cmd_ready", cmd_ready, 1'b1);
    applyStimulus(vecs[0], "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
